// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM states,
// requester encoding and the latched request record.
package dmem_pkg;

   localparam int unsigned DMEM_NB_WIDTH = 32;
   localparam int unsigned DMEM_NB_ADDR  = 9;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_MERGE  = 2'b10,
      ST_RESP   = 2'b11
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DU  = 1'b1
   } owner_e;

   typedef struct packed {
      owner_e                   owner;
      logic                     we;
      size_e                    size;
      logic                     uns;
      logic [DMEM_NB_ADDR-1:0]  addr;
      logic [DMEM_NB_WIDTH-1:0] wdata;
   } req_t;

   // Alignment rule for CPU accesses; size 11 is never legal.
   function automatic logic misaligned(input size_e size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU, debug-unit and RAM-side signal bundle of dmem_access_ctrl.
// slave = controller side, master = environment side.
interface dmem_access_ctrl_if
   import dmem_pkg::*;
#(
   parameter int unsigned NB_WIDTH = DMEM_NB_WIDTH,
   parameter int unsigned NB_ADDR  = DMEM_NB_ADDR
) ();

   logic                i_cpu_req;
   logic                i_cpu_we;
   logic [1:0]          i_cpu_size;
   logic                i_cpu_unsigned;
   logic [NB_ADDR-1:0]  i_cpu_addr;
   logic [NB_WIDTH-1:0] i_cpu_wdata;
   logic [NB_WIDTH-1:0] o_cpu_rdata;
   logic                o_cpu_ack;
   logic                o_cpu_err;
   logic                o_cpu_stall;

   logic                i_du_req;
   logic                i_du_we;
   logic [NB_ADDR-1:0]  i_du_addr;
   logic [NB_WIDTH-1:0] i_du_wdata;
   logic [NB_WIDTH-1:0] o_du_rdata;
   logic                o_du_ack;

   logic                o_mem_we;
   logic [NB_ADDR-1:0]  o_mem_addr;
   logic [NB_WIDTH-1:0] o_mem_wdata;
   logic [NB_WIDTH-1:0] i_mem_rdata;

   modport slave (
      input  i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
      output o_cpu_rdata, o_cpu_ack, o_cpu_err, o_cpu_stall,
      input  i_du_req, i_du_we, i_du_addr, i_du_wdata,
      output o_du_rdata, o_du_ack,
      output o_mem_we, o_mem_addr, o_mem_wdata,
      input  i_mem_rdata
   );

   modport master (
      output i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
      input  o_cpu_rdata, o_cpu_ack, o_cpu_err, o_cpu_stall,
      output i_du_req, i_du_we, i_du_addr, i_du_wdata,
      input  o_du_rdata, o_du_ack,
      input  o_mem_we, o_mem_addr, o_mem_wdata,
      output i_mem_rdata
   );

endinterface

// File: rtl/dmem_lane_merge.sv
// Big-endian sub-word lane handling: extract + extend for loads,
// lane insert into the RAM word for byte/half stores.
module dmem_lane_merge
   import dmem_pkg::*;
(
   input  size_e                    size_i,
   input  logic [1:0]               off_i,
   input  logic                     unsigned_i,
   input  logic [DMEM_NB_WIDTH-1:0] rdata_i,
   input  logic [DMEM_NB_WIDTH-1:0] wdata_i,
   output logic [DMEM_NB_WIDTH-1:0] load_data_c_o,
   output logic [DMEM_NB_WIDTH-1:0] merge_data_c_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Offset 0 is the most significant lane.
   always_comb begin
      case (off_i)
         2'd0:    byte_c = rdata_i[31:24];
         2'd1:    byte_c = rdata_i[23:16];
         2'd2:    byte_c = rdata_i[15:8];
         default: byte_c = rdata_i[7:0];
      endcase
      half_c = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
   end

   always_comb begin
      load_data_c_o = rdata_i;
      case (size_i)
         SZ_BYTE: load_data_c_o = unsigned_i ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
         SZ_HALF: load_data_c_o = unsigned_i ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
         default: load_data_c_o = rdata_i;
      endcase
   end

   always_comb begin
      merge_data_c_o = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            case (off_i)
               2'd0:    merge_data_c_o[31:24] = wdata_i[7:0];
               2'd1:    merge_data_c_o[23:16] = wdata_i[7:0];
               2'd2:    merge_data_c_o[15:8]  = wdata_i[7:0];
               default: merge_data_c_o[7:0]   = wdata_i[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off_i[1]) merge_data_c_o[15:0]  = wdata_i[15:0];
            else          merge_data_c_o[31:16] = wdata_i[15:0];
         end
         default: merge_data_c_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data RAM access sequencer: round-robin CPU/DU arbitration, sub-word RMW stores,
// sub-word load extension. Optional stall counter under `DMEM_STALL_CNT_EN.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned NB_WIDTH = DMEM_NB_WIDTH,
   parameter int unsigned NB_ADDR  = DMEM_NB_ADDR
) (
   input  logic               i_clk,
   input  logic               i_reset,
   dmem_access_ctrl_if.slave  bus_if
`ifdef DMEM_STALL_CNT_EN
   ,
   output logic [31:0]        o_stall_cnt
`endif
);

   state_e              state_q;
   owner_e              last_grant_q, last_grant_d;
   req_t                req_q, req_d;
   logic                err_d;
   logic                grant_c;

   logic                mem_we_q;
   logic [NB_ADDR-1:0]  mem_addr_q;
   logic [NB_WIDTH-1:0] mem_wdata_q;
   logic [NB_WIDTH-1:0] cpu_rdata_q;
   logic [NB_WIDTH-1:0] du_rdata_q;
   logic                cpu_ack_q, cpu_err_q, du_ack_q;

   logic [DMEM_NB_WIDTH-1:0] load_data_c;
   logic [DMEM_NB_WIDTH-1:0] merge_data_c;
   logic                     cpu_ack_c;

   dmem_lane_merge u_lane_merge (
      .size_i         (req_q.size),
      .off_i          (req_q.addr[1:0]),
      .unsigned_i     (req_q.uns),
      .rdata_i        (bus_if.i_mem_rdata),
      .wdata_i        (req_q.wdata),
      .load_data_c_o  (load_data_c),
      .merge_data_c_o (merge_data_c)
   );

   // Two-way round robin; the winner's request fields form req_d.
   always_comb begin
      last_grant_d = last_grant_q;
      req_d        = req_q;
      err_d        = 1'b0;
      grant_c      = bus_if.i_cpu_req | bus_if.i_du_req;
      if (bus_if.i_cpu_req && bus_if.i_du_req)
         last_grant_d = (last_grant_q == OWN_CPU) ? OWN_DU : OWN_CPU;
      else if (bus_if.i_cpu_req)
         last_grant_d = OWN_CPU;
      else if (bus_if.i_du_req)
         last_grant_d = OWN_DU;

      if (last_grant_d == OWN_CPU) begin
         req_d.owner = OWN_CPU;
         req_d.we    = bus_if.i_cpu_we;
         req_d.size  = size_e'(bus_if.i_cpu_size);
         req_d.uns   = bus_if.i_cpu_unsigned;
         req_d.addr  = bus_if.i_cpu_addr;
         req_d.wdata = bus_if.i_cpu_wdata;
         err_d       = misaligned(size_e'(bus_if.i_cpu_size), bus_if.i_cpu_addr[1:0]);
      end else begin
         req_d.owner = OWN_DU;
         req_d.we    = bus_if.i_du_we;
         req_d.size  = SZ_WORD;
         req_d.uns   = 1'b0;
         req_d.addr  = bus_if.i_du_addr;
         req_d.wdata = bus_if.i_du_wdata;
      end
   end

   // Access FSM; every output register is loaded on the transition into its state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= OWN_DU;
         req_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         du_rdata_q   <= '0;
         cpu_ack_q    <= 1'b0;
         cpu_err_q    <= 1'b0;
         du_ack_q     <= 1'b0;
      end else begin
         mem_we_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         cpu_err_q <= 1'b0;
         du_ack_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_c) begin
                  last_grant_q <= last_grant_d;
                  req_q        <= req_d;
                  if (err_d) begin
                     state_q     <= ST_RESP;
                     cpu_ack_q   <= 1'b1;
                     cpu_err_q   <= 1'b1;
                     cpu_rdata_q <= '0;
                  end else begin
                     state_q    <= ST_ACCESS;
                     mem_addr_q <= NB_ADDR'({req_d.addr[DMEM_NB_ADDR-1:2], 2'b00});
                     if (req_d.we && (req_d.size == SZ_WORD)) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= NB_WIDTH'(req_d.wdata);
                     end
                  end
               end
            end
            ST_ACCESS: begin
               if (req_q.we && (req_q.size != SZ_WORD)) begin
                  state_q     <= ST_MERGE;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= NB_WIDTH'(merge_data_c);
               end else begin
                  state_q <= ST_RESP;
                  if (req_q.owner == OWN_CPU) begin
                     cpu_ack_q <= 1'b1;
                     if (!req_q.we) cpu_rdata_q <= NB_WIDTH'(load_data_c);
                  end else begin
                     du_ack_q <= 1'b1;
                     if (!req_q.we) du_rdata_q <= bus_if.i_mem_rdata;
                  end
               end
            end
            ST_MERGE: begin
               state_q <= ST_RESP;
               if (req_q.owner == OWN_CPU) cpu_ack_q <= 1'b1;
               else                        du_ack_q  <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Reset suppresses the write strobe and acks in the same cycle it is raised.
   assign cpu_ack_c          = cpu_ack_q & ~i_reset;
   assign bus_if.o_mem_we    = mem_we_q & ~i_reset;
   assign bus_if.o_mem_addr  = mem_addr_q;
   assign bus_if.o_mem_wdata = mem_wdata_q;
   assign bus_if.o_cpu_rdata = cpu_rdata_q;
   assign bus_if.o_cpu_ack   = cpu_ack_c;
   assign bus_if.o_cpu_err   = cpu_err_q & ~i_reset;
   assign bus_if.o_cpu_stall = bus_if.i_cpu_req & ~cpu_ack_c;
   assign bus_if.o_du_rdata  = du_rdata_q;
   assign bus_if.o_du_ack    = du_ack_q & ~i_reset;

`ifdef DMEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of CPU stall cycles.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         stall_cnt_q <= '0;
      else if (bus_if.i_cpu_req && !cpu_ack_c && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, hand-written
// arbitration / reset sequences, and random traffic against a byte-array model.
module tb_dmem_access_ctrl;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl_if bus();

`ifdef DMEM_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   dmem_access_ctrl dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus_if  (bus)
`ifdef DMEM_STALL_CNT_EN
      ,
      .o_stall_cnt (stall_cnt)
`endif
   );

   // RAM: async read, synchronous word write
   logic [31:0] ram [128];
   assign bus.i_mem_rdata = ram[bus.o_mem_addr[8:2]];
   always @(posedge clk) if (bus.o_mem_we) ram[bus.o_mem_addr[8:2]] <= bus.o_mem_wdata;

   typedef struct {
      logic        du;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vq[$];
   logic [7:0] mb [512];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic du, input logic we, input logic [1:0] size,
                               input logic uns, input logic [8:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err, input int lat);
      vec_t v;
      v.du = du; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.err = err; v.lat = lat;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_size = 2'b00;
      bus.i_cpu_unsigned = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
      bus.i_du_req = 1'b0; bus.i_du_we = 1'b0; bus.i_du_addr = '0; bus.i_du_wdata = '0;
   endtask

   // One transaction; lat counts cycles from the grant cycle to the ack cycle.
   task automatic op(input logic is_du, input logic we, input logic [1:0] size, input logic uns,
                     input logic [8:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat, output int wes);
      @(posedge clk); #1;
      if (is_du) begin
         bus.i_du_req = 1'b1; bus.i_du_we = we; bus.i_du_addr = addr; bus.i_du_wdata = wdata;
      end else begin
         bus.i_cpu_req = 1'b1; bus.i_cpu_we = we; bus.i_cpu_size = size;
         bus.i_cpu_unsigned = uns; bus.i_cpu_addr = addr; bus.i_cpu_wdata = wdata;
      end
      lat = 0; wes = 0; rdata = '0; err = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (bus.o_mem_we) begin
            wes++;
            chk("mem_addr_align", 32'(bus.o_mem_addr[1:0]), 32'd0);
         end
         if (is_du ? bus.o_du_ack : bus.o_cpu_ack) begin
            lat = c;
            break;
         end
         if (!is_du) chk("cpu_stall_wait", 32'(bus.o_cpu_stall), 32'd1);
         // fields are only sampled at grant, so disturb them afterwards
         if (is_du) begin
            bus.i_du_we = 1'($urandom); bus.i_du_addr = 9'($urandom); bus.i_du_wdata = $urandom;
         end else begin
            bus.i_cpu_we = 1'($urandom); bus.i_cpu_size = 2'($urandom);
            bus.i_cpu_unsigned = 1'($urandom); bus.i_cpu_addr = 9'($urandom);
            bus.i_cpu_wdata = $urandom;
         end
      end
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got no ack within 20 cycles required an ack");
      end
      rdata = is_du ? bus.o_du_rdata : bus.o_cpu_rdata;
      err   = is_du ? 1'b0 : bus.o_cpu_err;
      if (!is_du) chk("cpu_stall_at_ack", 32'(bus.o_cpu_stall), 32'd0);
      idle_inputs();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, wes;
      string       order;
      int          got;

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_rdata", bus.o_cpu_rdata, 32'd0);
      chk("rst_cpu_ack", 32'(bus.o_cpu_ack), 32'd0);
      chk("rst_cpu_err", 32'(bus.o_cpu_err), 32'd0);
      chk("rst_cpu_stall", 32'(bus.o_cpu_stall), 32'd0);
      chk("rst_du_rdata", bus.o_du_rdata, 32'd0);
      chk("rst_du_ack", 32'(bus.o_du_ack), 32'd0);
      chk("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
      rst = 1'b0;

      // du, we, size, uns, addr, wdata, exp rdata, exp err, exp latency
      vq.push_back(mk(1, 1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0,        0, 2));
      vq.push_back(mk(1, 0, 2'b10, 0, 9'h010, 32'h0,        32'hDEADBEEF, 0, 2));
      vq.push_back(mk(1, 1, 2'b10, 0, 9'h020, 32'h11223344, 32'h0,        0, 2));
      vq.push_back(mk(0, 1, 2'b00, 0, 9'h021, 32'h000000AA, 32'h0,        0, 3));
      vq.push_back(mk(1, 0, 2'b10, 0, 9'h020, 32'h0,        32'h11AA3344, 0, 2));
      vq.push_back(mk(0, 1, 2'b01, 0, 9'h022, 32'h0000BEEF, 32'h0,        0, 3));
      vq.push_back(mk(1, 0, 2'b10, 0, 9'h020, 32'h0,        32'h11AABEEF, 0, 2));
      vq.push_back(mk(1, 1, 2'b10, 0, 9'h030, 32'h80FF7F01, 32'h0,        0, 2));
      vq.push_back(mk(0, 0, 2'b00, 0, 9'h030, 32'h0,        32'hFFFFFF80, 0, 2));
      vq.push_back(mk(0, 0, 2'b00, 1, 9'h030, 32'h0,        32'h00000080, 0, 2));
      vq.push_back(mk(0, 0, 2'b01, 0, 9'h032, 32'h0,        32'h00007F01, 0, 2));
      vq.push_back(mk(0, 0, 2'b01, 1, 9'h030, 32'h0,        32'h000080FF, 0, 2));
      vq.push_back(mk(0, 0, 2'b01, 0, 9'h030, 32'h0,        32'hFFFF80FF, 0, 2));
      vq.push_back(mk(0, 0, 2'b00, 0, 9'h033, 32'h0,        32'h00000001, 0, 2));
      vq.push_back(mk(0, 0, 2'b10, 0, 9'h031, 32'h0,        32'h0,        1, 1));
      vq.push_back(mk(0, 1, 2'b01, 0, 9'h033, 32'h00001234, 32'h0,        1, 1));
      vq.push_back(mk(1, 0, 2'b10, 0, 9'h030, 32'h0,        32'h80FF7F01, 0, 2));
      vq.push_back(mk(0, 0, 2'b11, 0, 9'h040, 32'h0,        32'h0,        1, 1));
      vq.push_back(mk(0, 1, 2'b10, 0, 9'h044, 32'hCAFEF00D, 32'h0,        0, 2));
      vq.push_back(mk(1, 0, 2'b10, 0, 9'h047, 32'h0,        32'hCAFEF00D, 0, 2));
      vq.push_back(mk(0, 0, 2'b10, 0, 9'h020, 32'h0,        32'h11AABEEF, 0, 2));

      foreach (vq[i]) begin
         op(vq[i].du, vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, rd, er, lat, wes);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vq[i].lat));
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vq[i].err));
         chk($sformatf("vec%0d_mem_we_cycles", i), 32'(wes), (vq[i].we && !vq[i].err) ? 32'd1 : 32'd0);
         if (!vq[i].we || vq[i].err)
            chk($sformatf("vec%0d_rdata", i), rd, vq[i].rdata);
      end

      // Arbitration: both requesters held high from reset release
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_size = 2'b10; bus.i_cpu_addr = 9'h010;
      bus.i_du_req = 1'b1; bus.i_du_we = 1'b0; bus.i_du_addr = 9'h020;
      order = ""; got = 0;
      for (int c = 0; c < 80 && got < 6; c++) begin
         @(posedge clk); #1;
         if (bus.o_cpu_ack) begin
            order = {order, "C"}; got++;
            chk("arb_cpu_rdata", bus.o_cpu_rdata, 32'hDEADBEEF);
         end
         if (bus.o_du_ack) begin
            order = {order, "D"}; got++;
            chk("arb_du_rdata", bus.o_du_rdata, 32'h11AABEEF);
         end
      end
      idle_inputs();
      checks++;
      if (order != "CDCDCD") begin
         errors++;
         $display("FAIL arb_order: got %s expected CDCDCD", order);
      end
      @(posedge clk); #1;

      // Reset raised during MERGE of a byte store
      op(1, 1, 2'b10, 0, 9'h050, 32'h55667788, rd, er, lat, wes);
      @(posedge clk); #1;
      bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_size = 2'b00;
      bus.i_cpu_addr = 9'h051; bus.i_cpu_wdata = 32'h00000099;
      @(posedge clk); #1;
      chk("rmw_access_we", 32'(bus.o_mem_we), 32'd0);
      @(posedge clk); #1;
      chk("rmw_merge_we", 32'(bus.o_mem_we), 32'd1);
      chk("rmw_merge_wdata", bus.o_mem_wdata, 32'h55997788);
      rst = 1'b1;
      #1;
      chk("rst_mid_we", 32'(bus.o_mem_we), 32'd0);
      idle_inputs();
      @(posedge clk); #1;
      chk("rst_mid_ack", 32'(bus.o_cpu_ack), 32'd0);
      chk("rst_mid_mem_we", 32'(bus.o_mem_we), 32'd0);
      chk("rst_mid_mem_wdata", bus.o_mem_wdata, 32'd0);
      chk("rst_mid_cpu_rdata", bus.o_cpu_rdata, 32'd0);
      chk("rst_mid_ram", ram[9'h050 >> 2], 32'h55667788);
      rst = 1'b0;
      op(1, 0, 2'b10, 0, 9'h050, 32'h0, rd, er, lat, wes);
      chk("rst_mid_readback", rd, 32'h55667788);
      chk("rst_mid_readback_lat", 32'(lat), 32'd2);

      // Random traffic on bytes 0..127 against a byte-array model
      for (int w = 0; w < 32; w++) begin
         logic [31:0] wd;
         wd = $urandom;
         op(1, 1, 2'b10, 0, 9'(w * 4), wd, rd, er, lat, wes);
         for (int b = 0; b < 4; b++) mb[w * 4 + b] = 8'(wd >> (8 * (3 - b)));
      end
      for (int t = 0; t < 120; t++) begin
         logic        r_du, r_we, r_uns, m_err;
         logic [1:0]  r_size;
         logic [8:0]  r_addr;
         logic [31:0] r_wdata, m_rd;
         int          nb, a, m_lat;
         r_du    = ($urandom_range(0, 3) == 0);
         r_we    = 1'($urandom_range(0, 1));
         r_size  = r_du ? 2'b10 : 2'($urandom_range(0, 3));
         r_uns   = 1'($urandom_range(0, 1));
         r_addr  = 9'($urandom_range(0, 127));
         r_wdata = $urandom;
         nb      = (r_size == 2'b00) ? 1 : (r_size == 2'b01) ? 2 : 4;
         a       = r_du ? (int'(r_addr) / 4) * 4 : int'(r_addr);
         m_err   = !r_du && ((r_size == 2'b11) || (a % nb != 0));
         m_rd    = '0;
         if (m_err) m_lat = 1;
         else if (r_we) begin
            m_lat = (nb < 4) ? 3 : 2;
            for (int i = 0; i < nb; i++) mb[a + i] = 8'(r_wdata >> (8 * (nb - 1 - i)));
         end else begin
            m_lat = 2;
            for (int i = 0; i < nb; i++) m_rd = (m_rd << 8) | 32'(mb[a + i]);
            if (!r_uns && nb < 4 && m_rd[8 * nb - 1]) m_rd = m_rd | ~((32'd1 << (8 * nb)) - 32'd1);
         end
         op(r_du, r_we, r_size, r_uns, r_addr, r_wdata, rd, er, lat, wes);
         chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(m_lat));
         chk($sformatf("rnd%0d_err", t), 32'(er), 32'(m_err));
         chk($sformatf("rnd%0d_mem_we_cycles", t), 32'(wes), (r_we && !m_err) ? 32'd1 : 32'd0);
         if (!r_we || m_err) chk($sformatf("rnd%0d_rdata", t), rd, m_rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
